isqrt_unit: RTL

ISQRT_UNIT -- requirements
Module: isqrt_unit

---
 rtl/isqrt_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/isqrt_unit.sv
// isqrt_unit: iterative integer square root, restoring method.
// Each cycle in ITER consumes two radicand bits (MSB first) and produces one root bit.
// Optional build macro: ISQRT_REMAINDER_EN adds the remainder output port and its register.
module isqrt_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   radicand,
   output logic               ready,
   output logic               done,
   output logic [WIDTH/2-1:0] root
`ifdef ISQRT_REMAINDER_EN
   ,
   output logic [WIDTH/2:0]   remainder
`endif
);

   localparam int HALF = WIDTH / 2;
   localparam int CW   = $clog2(HALF);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ITER   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  op_q, op_d;          // operand, shifted left two bits per step
   logic [HALF-1:0]   proot_q, proot_d;    // partial root
   logic [HALF+1:0]   prem_q, prem_d;      // partial remainder, top bit is the trial sign
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [HALF-1:0]   root_out_q, root_out_d;
   logic              done_q, done_d;
`ifdef ISQRT_REMAINDER_EN
   logic [HALF:0]     rem_out_q, rem_out_d;
`endif

   logic [HALF+1:0]   shifted;
   logic [HALF+1:0]   trial;

   // Digit step: bring down the next two radicand bits and subtract 4*root+1.
   // The true trial value always fits in HALF+2 signed bits, so modular arithmetic is exact.
   always_comb begin
      shifted = (prem_q << 2) | {{HALF{1'b0}}, op_q[WIDTH-1 -: 2]};
      trial   = shifted - {proot_q, 2'b01};
   end

   // Next-state and datapath updates for the three-state controller.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      proot_d    = proot_q;
      prem_d     = prem_q;
      cnt_d      = cnt_q;
      root_out_d = root_out_q;
      done_d     = 1'b0;
`ifdef ISQRT_REMAINDER_EN
      rem_out_d  = rem_out_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ITER;
               op_d    = radicand;
               proot_d = '0;
               prem_d  = '0;
               cnt_d   = CW'(HALF - 1);
            end
         end
         ITER: begin
            op_d = op_q << 2;
            if (trial[HALF+1]) begin
               // Negative trial: restore by keeping the shifted remainder.
               prem_d  = shifted;
               proot_d = {proot_q[HALF-2:0], 1'b0};
            end else begin
               prem_d  = trial;
               proot_d = {proot_q[HALF-2:0], 1'b1};
            end
            if (cnt_q == '0) begin
               state_d = FINISH;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         FINISH: begin
            root_out_d = proot_q;
`ifdef ISQRT_REMAINDER_EN
            rem_out_d  = prem_q[HALF:0];
`endif
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= '0;
         proot_q    <= '0;
         prem_q     <= '0;
         cnt_q      <= '0;
         root_out_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         proot_q    <= proot_d;
         prem_q     <= prem_d;
         cnt_q      <= cnt_d;
         root_out_q <= root_out_d;
         done_q     <= done_d;
      end
   end

`ifdef ISQRT_REMAINDER_EN
   // Remainder output register, loaded together with the root.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_out_q <= '0;
      end else begin
         rem_out_q <= rem_out_d;
      end
   end

   assign remainder = rem_out_q;
`endif

   assign ready = (state_q == IDLE);
   assign done  = done_q;
   assign root  = root_out_q;

endmodule
